// File: rtl/twiddle_seq_pkg.sv
// ---------------------------------------------------------------------------
// twiddle_seq_pkg
// Shared definitions for the twiddle factor sequencer:
//   NMAX_LOG2     - log2 of the largest supported FFT size (64 points)
//   DATA_W/TWID_W - width of one twiddle component / packed {T_r, T_i} word
//   state_e       - sequencer FSM encoding
//   TWIDDLE_TABLE - W_64^e for e = 0..31 (half wave), packed {T_r, T_i},
//                   12-bit two's complement with 10 fractional bits
// Optional feature macro used by the sequencer: TWIDDLE_SEQ_INVERSE_EN
// ---------------------------------------------------------------------------
package twiddle_seq_pkg;

  localparam int NMAX_LOG2 = 6;
  localparam int DATA_W    = 12;
  localparam int TWID_W    = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // T_r = round(1024*cos(2*pi*e/64)), T_i = round(-1024*sin(2*pi*e/64)).
  // Only the upper half plane is ever needed because radix-2 DIF exponents
  // never reach N/2, so 32 entries cover every supported FFT size.
  localparam logic [TWID_W-1:0] TWIDDLE_TABLE [32] = '{
    24'h400000, 24'h3FBF9C, 24'h3ECF38, 24'h3D4ED7,
    24'h3B2E78, 24'h387E1D, 24'h353DC7, 24'h318D76,
    24'h2D4D2C, 24'h28ACE8, 24'h239CAD, 24'h1E3C79,
    24'h188C4E, 24'h129C2C, 24'h0C8C14, 24'h064C05,
    24'h000C00, 24'hF9CC05, 24'hF38C14, 24'hED7C2C,
    24'hE78C4E, 24'hE1DC79, 24'hDC7CAD, 24'hD76CE8,
    24'hD2CD2C, 24'hCE8D76, 24'hCADDC7, 24'hC79E1D,
    24'hC4EE78, 24'hC2CED7, 24'hC14F38, 24'hC05F9C
  };

endpackage

// File: rtl/twiddle_rom.sv
// ---------------------------------------------------------------------------
// twiddle_rom
// Combinational twiddle lookup. The exponent of an N-point FFT is scaled to
// the 64-point table by shifting left by (6 - N_LOG2).
// Ports:
//   i_e    in  [4:0]  twiddle exponent e (0 .. N/2-1)
//   o_data out [23:0] {T_r, T_i} for W_N^e
// ---------------------------------------------------------------------------
module twiddle_rom
  import twiddle_seq_pkg::*;
#(
  parameter int N_LOG2 = 4
) (
  input  logic [NMAX_LOG2-2:0] i_e,
  output logic [TWID_W-1:0]    o_data
);

  localparam int SHIFT = NMAX_LOG2 - N_LOG2;

  logic [NMAX_LOG2-2:0] w_idx;

  // Scale the exponent to the 64-point table and read the packed entry
  assign w_idx  = i_e << SHIFT;
  assign o_data = TWIDDLE_TABLE[w_idx];

endmodule

// File: rtl/twiddle_seq.sv
// ---------------------------------------------------------------------------
// twiddle_seq
// Streams radix-2 DIF twiddle factors for an N = 2**N_LOG2 point FFT:
// stages s = 0..N_LOG2-1, butterflies k = 0..N/2-1, exponent
// e = (k mod (N >> (s+1))) << s, one beat per valid/ready handshake.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   one-cycle request to run a full sequence (ignored if busy)
//   busy     out  high in RUN and DONE
//   t_valid  out  beat present (RUN only)
//   t_ready  in   consumer accepts the beat
//   t_data   out  {T_r, T_i}, 12-bit signed Q1.10 each (registered)
//   t_stage  out  stage of the current beat (registered)
//   t_last   out  final beat of its stage (registered)
//   done     out  one-cycle pulse after the final beat transfers
//   inverse  in   only with TWIDDLE_SEQ_INVERSE_EN: sampled with start, selects
//                 conjugate twiddles (T_i negated) for the whole sequence
// ---------------------------------------------------------------------------
module twiddle_seq
  import twiddle_seq_pkg::*;
#(
  parameter int N_LOG2 = 4
) (
`ifdef TWIDDLE_SEQ_INVERSE_EN
  input  logic              inverse,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              t_valid,
  input  logic              t_ready,
  output logic [TWID_W-1:0] t_data,
  output logic [2:0]        t_stage,
  output logic              t_last,
  output logic              done
);

  localparam int          HALF_N = 1 << (N_LOG2 - 1);
  localparam logic [4:0]  K_MAX  = 5'(HALF_N - 1);
  localparam logic [2:0]  S_MAX  = 3'(N_LOG2 - 1);

  state_e              r_state;
  state_e              w_stateNext;
  logic [2:0]          r_s;
  logic [4:0]          r_k;
  logic [TWID_W-1:0]   r_data;
  logic                r_last;

  logic                w_xfer;
  logic                w_final;
  logic                w_load;
  logic [2:0]          w_beatS;
  logic [4:0]          w_beatK;
  logic                w_beatLast;
  logic [6:0]          w_span;
  logic [6:0]          w_mask;
  logic [4:0]          w_e;
  logic [TWID_W-1:0]   w_romData;
  logic [DATA_W-1:0]   w_ti;
  logic                w_invSel;

  assign w_xfer  = (r_state == RUN) && t_ready;
  assign w_final = (r_s == S_MAX) && (r_k == K_MAX);
  // Output registers are loaded with the first beat on an accepted start and
  // with the following beat on every transfer except the final one.
  assign w_load  = ((r_state == IDLE) && start) || (w_xfer && !w_final);

  // Coordinates of the beat to present next: (0,0) when starting, otherwise
  // the successor of the current beat with k wrapping into the next stage.
  always_comb begin
    w_beatS = 3'd0;
    w_beatK = 5'd0;
    if (r_state == RUN) begin
      if (r_k == K_MAX) begin
        w_beatS = r_s + 3'd1;
        w_beatK = 5'd0;
      end else begin
        w_beatS = r_s;
        w_beatK = r_k + 5'd1;
      end
    end
  end

  // Exponent of the next beat: k modulo the butterfly span of its stage,
  // scaled by the stage number. The span N >> (s+1) is a power of two, so
  // the modulo is a mask.
  assign w_span     = 7'(1 << N_LOG2) >> (w_beatS + 3'd1);
  assign w_mask     = w_span - 7'd1;
  assign w_e        = 5'(({2'b00, w_beatK} & w_mask) << w_beatS);
  assign w_beatLast = (w_beatK == K_MAX);

  twiddle_rom #(
    .N_LOG2 (N_LOG2)
  ) u_rom (
    .i_e    (w_e),
    .o_data (w_romData)
  );

`ifdef TWIDDLE_SEQ_INVERSE_EN
  logic r_inverse;

  // Direction is captured with start so the caller may change it mid-run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inverse <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_inverse <= inverse;
    end
  end

  // The first beat is loaded in the same cycle inverse is captured, so it
  // must see the live port value rather than the register.
  assign w_invSel = (r_state == IDLE) ? inverse : r_inverse;
`else
  assign w_invSel = 1'b0;
`endif

  // Conjugation only flips the sign of the imaginary part
  assign w_ti = w_invSel ? (12'd0 - w_romData[DATA_W-1:0]) : w_romData[DATA_W-1:0];

  // Beat counters and registered beat outputs; t_stage is the stage counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= 3'd0;
      r_k    <= 5'd0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      r_s    <= w_beatS;
      r_k    <= w_beatK;
      r_data <= {w_romData[TWID_W-1:DATA_W], w_ti};
      r_last <= w_beatLast;
    end
  end

  assign t_data  = r_data;
  assign t_stage = r_s;
  assign t_last  = r_last;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // FSM next state and status outputs; start is only honoured in IDLE
  always_comb begin
    w_stateNext = r_state;
    busy        = 1'b0;
    t_valid     = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        t_valid = 1'b1;
        if (w_xfer && w_final) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_twiddle_seq.sv
// ---------------------------------------------------------------------------
// tb_twiddle_seq
// Scoreboard bench for twiddle_seq with N_LOG2 = 3 (12 beats per sequence).
// Stimulus pushes the hand-computed beats of a sequence when it issues start;
// a monitor pops and compares on every handshake, checks stall stability and
// the done pulse. Inverse twiddles are exercised when TWIDDLE_SEQ_INVERSE_EN
// is defined.
// ---------------------------------------------------------------------------
module tb_twiddle_seq;

  localparam int NLOG2 = 3;
  localparam int BEATS = 12;

  typedef struct packed {
    logic [23:0] data;
    logic [2:0]  stage;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        tReady;
  logic        busy;
  logic        tValid;
  logic [23:0] tData;
  logic [2:0]  tStage;
  logic        tLast;
  logic        done;
`ifdef TWIDDLE_SEQ_INVERSE_EN
  logic        inverse;
`endif

  beat_t expQ[$];
  int    checks    = 0;
  int    fails     = 0;
  int    xferCount = 0;
  int    doneCount = 0;

  always #5 clk = ~clk;

  twiddle_seq #(
    .N_LOG2 (NLOG2)
  ) dut (
`ifdef TWIDDLE_SEQ_INVERSE_EN
    .inverse (inverse),
`endif
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .t_valid (tValid),
    .t_ready (tReady),
    .t_data  (tData),
    .t_stage (tStage),
    .t_last  (tLast),
    .done    (done)
  );

  // Single comparison point shared by stimulus and monitor
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Hand-computed 8-point twiddles for e = 0..3, forward and conjugate
  function automatic beat_t modelBeat(input int s, input int k, input bit inv);
    beat_t b;
    int    e;
    e = (k % ((1 << NLOG2) >> (s + 1))) << s;
    case (e)
      0:       b.data = 24'h400000;
      1:       b.data = inv ? 24'h2D42D4 : 24'h2D4D2C;
      2:       b.data = inv ? 24'h000400 : 24'h000C00;
      default: b.data = inv ? 24'hD2C2D4 : 24'hD2CD2C;
    endcase
    b.stage = 3'(s);
    b.last  = (k == 3);
    return b;
  endfunction

  // Pulse start for one cycle and queue the expected sequence
  task automatic applyStimulus(input bit inv);
    @(posedge clk);
    #1;
    start = 1'b1;
`ifdef TWIDDLE_SEQ_INVERSE_EN
    inverse = inv;
`endif
    for (int s = 0; s < NLOG2; s++) begin
      for (int k = 0; k < 4; k++) begin
        expQ.push_back(modelBeat(s, k, inv));
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef TWIDDLE_SEQ_INVERSE_EN
    inverse = ~inv;
`endif
  endtask

  // Run one sequence with a ready pattern and an optional start pulse while
  // running, then check completion, transfer count and return to idle
  task automatic runSequence(input string name, input bit inv,
                             input logic [15:0] pat, input int startAt);
    int x0;
    int d0;
    int cyc;
    x0     = xferCount;
    d0     = doneCount;
    tReady = pat[0];
    applyStimulus(inv);
    cyc = 0;
    while (doneCount == d0 && cyc < 300) begin
      tReady = pat[cyc % 16];
      start  = (cyc == startAt);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    checkOutput({name, "_doneSeen"}, doneCount - d0, 1);
    checkOutput({name, "_xfers"}, xferCount - x0, BEATS);
    checkOutput({name, "_busyAfter"}, {31'd0, busy}, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput({name, "_idleAfter"}, {31'd0, tValid}, 0);
  endtask

  // Abort a sequence after five transfers with an asynchronous reset
  task automatic resetMidSequence();
    int x0;
    int cyc;
    x0     = xferCount;
    tReady = 1'b1;
    applyStimulus(1'b0);
    cyc = 0;
    while ((xferCount - x0) < 5 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("reachedBeat5", xferCount - x0, 5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncValid", {31'd0, tValid}, 0);
    checkOutput("asyncBusy", {31'd0, busy}, 0);
    checkOutput("asyncDone", {31'd0, done}, 0);
    checkOutput("asyncStage", {29'd0, tStage}, 0);
    checkOutput("asyncData", {8'd0, tData}, 0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("noBeatAfterReset", {31'd0, tValid}, 0);
    end
  endtask

  // Monitor: samples on the falling edge, so a handshake seen here is the
  // transfer at the following rising edge
  initial begin
    beat_t cur;
    beat_t expB;
    beat_t heldBeat;
    bit    holdValid;
    bit    prevFinalXfer;
    holdValid     = 1'b0;
    prevFinalXfer = 1'b0;
    heldBeat      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holdValid     = 1'b0;
        prevFinalXfer = 1'b0;
      end else begin
        if (done) begin
          checkOutput("donePulse", {31'd0, prevFinalXfer}, 1);
          checkOutput("queueEmptyAtDone", expQ.size(), 0);
          doneCount++;
        end
        prevFinalXfer = 1'b0;
        if (tValid) begin
          cur = {tData, tStage, tLast};
          if (holdValid) begin
            checkOutput("stallHold", {4'd0, cur}, {4'd0, heldBeat});
          end
          if (tReady) begin
            if (expQ.size() == 0) begin
              checks++;
              fails++;
              $display("[TB] FAIL unexpectedBeat: actual=%h expected=none", cur);
            end else begin
              expB = expQ.pop_front();
              checkOutput($sformatf("beat%0d", xferCount), {4'd0, cur}, {4'd0, expB});
            end
            xferCount++;
            prevFinalXfer = (tStage == 3'(NLOG2 - 1)) && tLast;
            holdValid     = 1'b0;
          end else begin
            holdValid = 1'b1;
            heldBeat  = cur;
          end
        end else begin
          holdValid = 1'b0;
        end
      end
    end
  end

  // Directed scenario sequence
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    tReady = 1'b0;
`ifdef TWIDDLE_SEQ_INVERSE_EN
    inverse = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetValid", {31'd0, tValid}, 0);
    checkOutput("resetBusy", {31'd0, busy}, 0);
    checkOutput("resetDone", {31'd0, done}, 0);
    checkOutput("resetData", {8'd0, tData}, 0);
    checkOutput("resetStage", {29'd0, tStage}, 0);
    checkOutput("resetLast", {31'd0, tLast}, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleNoBeat", {31'd0, tValid}, 0);

    $display("[TB] full-rate sequence");
    runSequence("fullRate", 1'b0, 16'hFFFF, -1);
    $display("[TB] sequence with ready stalls");
    runSequence("stalled", 1'b0, 16'b1011_0110_1110_0101, -1);
    $display("[TB] start pulsed while running");
    runSequence("startInRun", 1'b0, 16'hFFFF, 4);
    $display("[TB] reset at beat 5");
    resetMidSequence();
    runSequence("afterReset", 1'b0, 16'hFFFF, -1);
`ifdef TWIDDLE_SEQ_INVERSE_EN
    $display("[TB] inverse twiddles");
    runSequence("inverse", 1'b1, 16'b1101_1011_0111_1110, -1);
    runSequence("forwardAgain", 1'b0, 16'hFFFF, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/twiddle_seq.md
TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Interface
REQ-001 Parameter: N_LOG2, default 4, log2 of FFT size N; legal range 2..6.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  one-cycle request to begin a full twiddle sequence.
REQ-005 Port: busy  output  1  high from accepted start until done.
REQ-006 Port: t_valid  output  1  t_data/t_stage/t_last hold a valid twiddle beat.
REQ-007 Port: t_ready  input  1  consumer (butterfly/twiddle multiplier) accepts the beat.
REQ-008 Port: t_data  output  24  {T_r, T_i}, each 12-bit signed with 10 fractional bits.
REQ-009 Port: t_stage  output  3  stage number of the current beat.
REQ-010 Port: t_last  output  1  current beat is the final beat of its stage.
REQ-011 Port: done  output  1  one-cycle pulse after the final beat of the final stage transfers.

Function
REQ-012 The block SHALL stream radix-2 DIF twiddle factors: stages s = 0..N_LOG2-1, butterfly index k = 0..N/2-1 per stage, N_LOG2*N/2 beats in total.
REQ-013 Beat (s,k) SHALL carry W_N^e, with e = (k mod (N>>(s+1))) << s.
REQ-014 T_r SHALL be round(1024*cos(2*pi*e/N)) and T_i SHALL be round(-1024*sin(2*pi*e/N)), two's complement, 12 bits.
REQ-015 FSM states: IDLE, RUN, DONE. IDLE->RUN on start; RUN->DONE on handshake of beat (N_LOG2-1, N/2-1); DONE->IDLE unconditionally after one cycle.
REQ-016 The first beat SHALL have t_valid high in the cycle after start is sampled in IDLE.
REQ-017 A beat transfers only when t_valid && t_ready; k and s SHALL advance only on transfer, with k wrapping to 0 and s incrementing at k = N/2-1.
REQ-018 While t_valid && !t_ready, t_data, t_stage and t_last SHALL hold stable.
REQ-019 Back-to-back transfers SHALL sustain one beat per cycle while t_ready is held high.
REQ-020 start SHALL be ignored in RUN and DONE.
REQ-021 done SHALL be high only in DONE; busy SHALL be high in RUN and DONE.
REQ-022 t_data, t_stage and t_last SHALL be registered outputs; t_valid SHALL be high only in RUN.

Reset
REQ-023 On rst high, the FSM SHALL enter IDLE immediately, regardless of clk, including mid-sequence.
REQ-024 Reset values: busy=0, t_valid=0, t_data=24'h000000, t_stage=0, t_last=0, done=0, s=0, k=0.
REQ-025 After rst is released, no beat SHALL be produced until a new start.

Configuration
REQ-026 Macro TWIDDLE_SEQ_INVERSE_EN SHALL add input port inverse (1 bit), sampled with start and held for the whole sequence.
REQ-027 With the macro and inverse=1, T_i SHALL be negated, giving the conjugate W_N^-e for IFFT.
REQ-028 Without the macro, the inverse port SHALL be absent and output SHALL always be forward twiddles.

Structure
REQ-029 A shared package SHALL hold NMAX_LOG2=6, the data widths (12/24), the FSM state encoding, and the 32-entry quarter/half-wave table for N=64.
REQ-030 Sub-module twiddle_rom SHALL perform the combinational lookup of table index e << (6-N_LOG2), returning {T_r, T_i}.

Verification
REQ-031 N_LOG2=3, start, t_ready=1: 12 beats; stage 0 e=0,1,2,3 -> t_data 24'h400000, 24'h2D4D2C, 24'h000C00, 24'hD2CD2C; done pulses one cycle after beat 12.
REQ-032 N_LOG2=3: stage 1 e=0,2,0,2 with t_last on the 4th beat; stage 2 emits all 24'h400000 with t_stage=2.
REQ-033 Random t_ready deassertion: t_data held stable while stalled; beat order and values unchanged; total 12 transfers.
REQ-034 start pulsed during RUN: ignored, with no restart and beat count unchanged.
REQ-035 rst asserted at beat 5: t_valid, busy and done drop asynchronously; after release and a new start, the sequence restarts from (s=0,k=0).
REQ-036 TWIDDLE_SEQ_INVERSE_EN defined, inverse=1, N_LOG2=3: beat e=1 yields 24'h2D42D4 and e=2 yields 24'h000400.
